// File: rtl/mem_arb_pkg.sv
// Shared types for the memory request arbiter: FSM states, arbitration
// modes and the core's memory operation type with a strobe helper.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_e;

  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;

  // Memory operation type issued by the core's load/store unit.
  typedef enum logic [3:0] {
    CU_NOP = 4'd0,
    CU_LB  = 4'd1,
    CU_LH  = 4'd2,
    CU_LW  = 4'd3,
    CU_LBU = 4'd4,
    CU_LHU = 4'd5,
    CU_SB  = 4'd6,
    CU_SH  = 4'd7,
    CU_SW  = 4'd8
  } cuOPType;

  // True for operations that drive the write port.
  function automatic logic cu_is_store(input cuOPType op);
    return (op == CU_SB) || (op == CU_SH) || (op == CU_SW);
  endfunction

  // Byte strobes for a 32-bit word: SB selects one lane at addr[1:0], SH
  // selects the aligned half-word, everything else selects the whole word.
  function automatic logic [3:0] cu_strb(input cuOPType op, input logic [1:0] addr_lo);
    logic [3:0] s;
    case (op)
      CU_SB:   s = 4'b0001 << addr_lo;
      CU_SH:   s = addr_lo[1] ? 4'b1100 : 4'b0011;
      default: s = 4'b1111;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/rr_grant.sv
// Combinational grant picker: lowest-index request in fixed mode, or the
// first request found after last_grant (wrapping) in round-robin mode.
module rr_grant
  import mem_arb_pkg::*;
#(
  parameter int NPORTS = 2,
  parameter int IDX_W  = $clog2(NPORTS)
) (
  input  logic [NPORTS-1:0] req_i,
  input  logic [IDX_W-1:0]  last_grant_i,
  input  logic              rr_mode_i,
  output logic [IDX_W-1:0]  grant_o,
  output logic              valid_o
);

  // cand_idx[s] is the port examined in search slot s; slot 0 is searched first.
  logic [IDX_W-1:0] cand_idx [NPORTS];

  for (genvar gi = 0; gi < NPORTS; gi++) begin : g_cand
    logic [IDX_W:0] rr_sum;
    // last_grant + 1 + slot never exceeds 2*NPORTS-1, so one subtraction wraps it.
    assign rr_sum = {1'b0, last_grant_i} + (IDX_W+1)'(gi + 1);
    assign cand_idx[gi] = !rr_mode_i                    ? IDX_W'(gi) :
                          (rr_sum >= (IDX_W+1)'(NPORTS)) ? IDX_W'(rr_sum - (IDX_W+1)'(NPORTS)) :
                                                          rr_sum[IDX_W-1:0];
  end

  // Scan slots from last to first so the earliest slot holding a request wins.
  always_comb begin
    grant_o = '0;
    valid_o = 1'b0;
    for (int i = NPORTS - 1; i >= 0; i--) begin
      if (req_i[cand_idx[i]]) begin
        grant_o = cand_idx[i];
        valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_request_arbiter.sv
// N-port memory request arbiter sharing one RAM port. Three-state FSM:
// IDLE picks a requester and latches its command, ACCESS drives the RAM
// until ram_busy drops (or the timeout expires), RESP presents ack/err.
module mem_request_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NPORTS   = 2,
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int ARB_MODE = 0,
  parameter int TIMEOUT  = 255
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic [NPORTS-1:0]          req,
  input  logic [NPORTS-1:0]          we,
  input  logic [NPORTS*ADDR_W-1:0]   addr,
  input  logic [NPORTS*DATA_W-1:0]   wdata,
  input  logic [NPORTS*DATA_W/8-1:0] strb,
  output logic [NPORTS-1:0]          ack,
  output logic [NPORTS-1:0]          err,
  output logic [DATA_W-1:0]          rdata,
  output logic                       Ren,
  output logic                       Wen,
  output logic [ADDR_W-1:0]          ramaddr,
  output logic [DATA_W-1:0]          ramstore,
  output logic [DATA_W/8-1:0]        ramstrb,
  input  logic [DATA_W-1:0]          ramload,
  input  logic                       ram_busy
);

  localparam int IDX_W  = $clog2(NPORTS);
  localparam int STRB_W = DATA_W / 8;
  localparam int CNT_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  // Per-port views of the packed request buses.
  logic [ADDR_W-1:0] addr_a  [NPORTS];
  logic [DATA_W-1:0] wdata_a [NPORTS];
  logic [STRB_W-1:0] strb_a  [NPORTS];

  for (genvar gi = 0; gi < NPORTS; gi++) begin : g_unpack
    assign addr_a[gi]  = addr[gi*ADDR_W +: ADDR_W];
    assign wdata_a[gi] = wdata[gi*DATA_W +: DATA_W];
    assign strb_a[gi]  = strb[gi*STRB_W +: STRB_W];
  end

  arb_state_e        state_q, state_d;
  logic [IDX_W-1:0]  grant_q, grant_d;
  logic [IDX_W-1:0]  last_grant_q, last_grant_d;
  logic              we_q, we_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ren_q, ren_d;
  logic              wen_q, wen_d;
  logic [ADDR_W-1:0] ramaddr_q, ramaddr_d;
  logic [DATA_W-1:0] ramstore_q, ramstore_d;
  logic [STRB_W-1:0] ramstrb_q, ramstrb_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [NPORTS-1:0] ack_q, ack_d;
  logic [NPORTS-1:0] err_q, err_d;

  logic [IDX_W-1:0]  gnt_idx;
  logic              gnt_valid;

  rr_grant #(
    .NPORTS (NPORTS),
    .IDX_W  (IDX_W)
  ) u_rr_grant (
    .req_i        (req),
    .last_grant_i (last_grant_q),
    .rr_mode_i    (ARB_MODE == ARB_RR),
    .grant_o      (gnt_idx),
    .valid_o      (gnt_valid)
  );

  // Next-state and registered-output logic; ack/err default low so they pulse.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    we_d         = we_q;
    cnt_d        = cnt_q;
    ren_d        = ren_q;
    wen_d        = wen_q;
    ramaddr_d    = ramaddr_q;
    ramstore_d   = ramstore_q;
    ramstrb_d    = ramstrb_q;
    rdata_d      = rdata_q;
    ack_d        = '0;
    err_d        = '0;

    case (state_q)
      IDLE: begin
        if (gnt_valid) begin
          state_d      = ACCESS;
          grant_d      = gnt_idx;
          last_grant_d = gnt_idx;
          we_d         = we[gnt_idx];
          ren_d        = !we[gnt_idx];
          wen_d        = we[gnt_idx];
          ramaddr_d    = addr_a[gnt_idx];
          ramstore_d   = wdata_a[gnt_idx];
          // Reads present a full-word strobe to the RAM.
          ramstrb_d    = we[gnt_idx] ? strb_a[gnt_idx] : '1;
          cnt_d        = '0;
        end
      end

      ACCESS: begin
        if (!ram_busy) begin
          state_d        = RESP;
          ren_d          = 1'b0;
          wen_d          = 1'b0;
          ack_d[grant_q] = 1'b1;
          if (!we_q) begin
            rdata_d = ramload;
          end
        end else if ((TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT))) begin
          // Abandon the access; rdata keeps its previous value.
          state_d        = RESP;
          ren_d          = 1'b0;
          wen_d          = 1'b0;
          err_d[grant_q] = 1'b1;
        end else if (TIMEOUT != 0) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      RESP: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and command registers; reset clears every output immediately.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_grant_q <= IDX_W'(NPORTS - 1);
      we_q         <= 1'b0;
      cnt_q        <= '0;
      ren_q        <= 1'b0;
      wen_q        <= 1'b0;
      ramaddr_q    <= '0;
      ramstore_q   <= '0;
      ramstrb_q    <= '0;
      rdata_q      <= '0;
      ack_q        <= '0;
      err_q        <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      we_q         <= we_d;
      cnt_q        <= cnt_d;
      ren_q        <= ren_d;
      wen_q        <= wen_d;
      ramaddr_q    <= ramaddr_d;
      ramstore_q   <= ramstore_d;
      ramstrb_q    <= ramstrb_d;
      rdata_q      <= rdata_d;
      ack_q        <= ack_d;
      err_q        <= err_d;
    end
  end

  assign Ren      = ren_q;
  assign Wen      = wen_q;
  assign ramaddr  = ramaddr_q;
  assign ramstore = ramstore_q;
  assign ramstrb  = ramstrb_q;
  assign rdata    = rdata_q;
  assign ack      = ack_q;
  assign err      = err_q;

endmodule

// File: tb/tb_mem_request_arbiter.sv
// Scoreboard bench: dut_f is a 2-port fixed-priority arbiter with a short
// timeout, dut_r a 4-port round-robin one. The RAM model returns
// ramaddr ^ KEY and holds ram_busy for a configurable number of cycles.
module tb_mem_request_arbiter;
  import mem_arb_pkg::*;

  localparam logic [31:0] KEY = 32'hb9f9b9f9;
  localparam int          TMO = 4;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic rst_f, rst_r;

  logic [1:0]   req_f, we_f, ack_f, err_f;
  logic [63:0]  addr_f, wdata_f;
  logic [7:0]   strb_f;
  logic [31:0]  rdata_f, ramaddr_f, ramstore_f, ramload_f;
  logic [3:0]   ramstrb_f;
  logic         ren_f, wen_f, busy_f;

  logic [3:0]   req_r, we_r, ack_r, err_r;
  logic [127:0] addr_r, wdata_r;
  logic [15:0]  strb_r;
  logic [31:0]  rdata_r, ramaddr_r, ramstore_r, ramload_r;
  logic [3:0]   ramstrb_r;
  logic         ren_r, wen_r, busy_r;

  assign ramload_f = ramaddr_f ^ KEY;
  assign ramload_r = ramaddr_r ^ KEY;

  mem_request_arbiter #(.NPORTS(2), .ADDR_W(32), .DATA_W(32), .ARB_MODE(ARB_FIXED), .TIMEOUT(TMO)) dut_f (
    .CLK(CLK), .RST(rst_f), .req(req_f), .we(we_f), .addr(addr_f), .wdata(wdata_f), .strb(strb_f),
    .ack(ack_f), .err(err_f), .rdata(rdata_f), .Ren(ren_f), .Wen(wen_f), .ramaddr(ramaddr_f),
    .ramstore(ramstore_f), .ramstrb(ramstrb_f), .ramload(ramload_f), .ram_busy(busy_f));

  mem_request_arbiter #(.NPORTS(4), .ADDR_W(32), .DATA_W(32), .ARB_MODE(ARB_RR), .TIMEOUT(TMO)) dut_r (
    .CLK(CLK), .RST(rst_r), .req(req_r), .we(we_r), .addr(addr_r), .wdata(wdata_r), .strb(strb_r),
    .ack(ack_r), .err(err_r), .rdata(rdata_r), .Ren(ren_r), .Wen(wen_r), .ramaddr(ramaddr_r),
    .ramstore(ramstore_r), .ramstrb(ramstrb_r), .ramload(ramload_r), .ram_busy(busy_r));

  typedef struct {
    int          port;
    bit          is_err;
    bit          we;
    logic [31:0] addr;
    logic [31:0] store;
    logic [3:0]  strb;
    logic [31:0] rdata;
    int          len;
  } sb_t;

  sb_t q_f[$];
  sb_t q_r[$];

  int n_checks = 0;
  int n_fail   = 0;

  int          rem [2][4];
  int          busy_cfg [2];
  int          acc_len [2];
  logic [31:0] acc_addr [2];
  logic [31:0] acc_store [2];
  logic [3:0]  acc_strb [2];
  bit          acc_we [2];
  logic [31:0] model_rd [2];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_port(input int inst, input int p, input logic w, input logic [31:0] a,
                          input logic [31:0] d, input logic [3:0] s);
    if (inst == 0) begin
      we_f[p] = w; addr_f[p*32 +: 32] = a; wdata_f[p*32 +: 32] = d; strb_f[p*4 +: 4] = s;
    end else begin
      we_r[p] = w; addr_r[p*32 +: 32] = a; wdata_r[p*32 +: 32] = d; strb_r[p*4 +: 4] = s;
    end
  endtask

  // Push the expected completion; rdata follows the RAM model on successful reads only.
  task automatic expect_txn(input int inst, input int port, input bit is_err, input bit w,
                            input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            input int len);
    sb_t e;
    if (!is_err && !w) model_rd[inst] = a ^ KEY;
    e.port = port; e.is_err = is_err; e.we = w; e.addr = a; e.store = d;
    e.strb = s; e.rdata = model_rd[inst]; e.len = len;
    if (inst == 0) q_f.push_back(e); else q_r.push_back(e);
  endtask

  task automatic update_req();
    for (int p = 0; p < 2; p++) req_f[p] = (rem[0][p] > 0);
    for (int p = 0; p < 4; p++) req_r[p] = (rem[1][p] > 0);
  endtask

  function automatic int pending();
    int s = 0;
    for (int i = 0; i < 2; i++)
      for (int p = 0; p < 4; p++) s += rem[i][p];
    return s + q_f.size() + q_r.size();
  endfunction

  task automatic monitor(input int inst, input logic ren, input logic wen, input logic [31:0] ra,
                         input logic [31:0] rs, input logic [3:0] rstb, input logic [3:0] ackv,
                         input logic [3:0] errv, input logic [31:0] rd, output logic busy);
    sb_t        e;
    bit         got;
    logic [7:0] exp_v;
    busy = 1'b0;
    if (ren && wen) check("ren_wen_exclusive", 1, 0);
    if (ren || wen) begin
      busy = (acc_len[inst] < busy_cfg[inst]);
      acc_len[inst]++;
      acc_addr[inst] = ra; acc_store[inst] = rs; acc_strb[inst] = rstb; acc_we[inst] = wen;
    end
    if ((ackv | errv) != 4'b0) begin
      got = 1'b0;
      if (inst == 0 && q_f.size() > 0) begin e = q_f.pop_front(); got = 1'b1; end
      else if (inst == 1 && q_r.size() > 0) begin e = q_r.pop_front(); got = 1'b1; end
      if (!got) begin
        check("unexpected_response", {errv, ackv}, 8'h00);
      end else begin
        exp_v = e.is_err ? (8'h10 << e.port) : (8'h01 << e.port);
        check("resp_port", {errv, ackv}, exp_v);
        check("access_len", acc_len[inst], e.len);
        check("ramaddr", acc_addr[inst], e.addr);
        check("access_we", acc_we[inst], e.we);
        check("ramstrb", acc_strb[inst], e.strb);
        if (e.we) check("ramstore", acc_store[inst], e.store);
        check("rdata", rd, e.rdata);
        $display("txn inst=%0d port=%0d %s %s addr=0x%08h rdata=0x%08h len=%0d", inst, e.port,
                 e.we ? "WR" : "RD", e.is_err ? "err" : "ack", acc_addr[inst], rd, acc_len[inst]);
      end
      for (int p = 0; p < 4; p++)
        if ((ackv[p] || errv[p]) && rem[inst][p] > 0) rem[inst][p]--;
      acc_len[inst] = 0;
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
    monitor(0, ren_f, wen_f, ramaddr_f, ramstore_f, ramstrb_f, {2'b00, ack_f}, {2'b00, err_f}, rdata_f, busy_f);
    monitor(1, ren_r, wen_r, ramaddr_r, ramstore_r, ramstrb_r, ack_r, err_r, rdata_r, busy_r);
    update_req();
  endtask

  // Run until every expected completion has appeared; n is the number of edges used.
  task automatic run(input int budget, output int n);
    update_req();
    n = 0;
    while (pending() > 0 && n < budget) begin
      tick();
      n++;
    end
    check("done_within_budget", (pending() == 0), 1);
    tick();
    tick();
  endtask

  task automatic reset_r();
    @(negedge CLK);
    rst_r = 1'b1;
    q_r.delete();
    for (int p = 0; p < 4; p++) rem[1][p] = 0;
    acc_len[1] = 0; model_rd[1] = '0; busy_r = 1'b0;
    update_req();
    @(negedge CLK);
    @(negedge CLK);
    rst_r = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_f = 1'b1; rst_r = 1'b1;
    req_f = '0; we_f = '0; addr_f = '0; wdata_f = '0; strb_f = '0; busy_f = 1'b0;
    req_r = '0; we_r = '0; addr_r = '0; wdata_r = '0; strb_r = '0; busy_r = 1'b0;
    for (int i = 0; i < 2; i++) begin
      for (int p = 0; p < 4; p++) rem[i][p] = 0;
      busy_cfg[i] = 0; acc_len[i] = 0; model_rd[i] = '0;
    end
    repeat (2) @(negedge CLK);

    check("rst_ren", ren_f, 0);
    check("rst_wen", wen_f, 0);
    check("rst_ack", ack_f, 0);
    check("rst_err", err_f, 0);
    check("rst_rdata", rdata_f, 0);
    check("rst_ramaddr", ramaddr_f, 0);
    check("rst_ramstrb", ramstrb_f, 0);
    check("rst_ramstore", ramstore_f, 0);
    check("rst_r_outputs", {ren_r, wen_r, ack_r, err_r}, 0);
    rst_f = 1'b0; rst_r = 1'b0;

    check("cu_strb_sb", cu_strb(CU_SB, 2'b10), 4'b0100);
    check("cu_strb_sh", cu_strb(CU_SH, 2'b10), 4'b1100);
    check("cu_strb_sw", cu_strb(CU_SW, 2'b00), 4'b1111);

    // Single read, one busy cycle: Ren for 2 cycles, ack 3 edges after req.
    set_port(0, 0, 1'b0, 32'habcdabcd, 32'h0, 4'h0);
    busy_cfg[0] = 1;
    expect_txn(0, 0, 1'b0, 1'b0, 32'habcdabcd, 32'h0, 4'hf, 2);
    rem[0][0] = 1;
    run(50, n);
    check("read_latency", n, 3);
    check("read_rdata_held", rdata_f, 32'h12341234);

    // Byte store from port 1; rdata must not change.
    set_port(0, 1, 1'b1, 32'habcdabcd, 32'h33333333, 4'b0001);
    busy_cfg[0] = 0;
    expect_txn(0, 1, 1'b0, 1'b1, 32'habcdabcd, 32'h33333333, 4'b0001, 1);
    rem[0][1] = 1;
    run(50, n);
    check("store_latency", n, 2);

    // Simultaneous requests, fixed priority: port 0 then port 1, 3 cycles apart.
    set_port(0, 0, 1'b0, 32'h00000100, 32'h0, 4'h0);
    set_port(0, 1, 1'b1, 32'h00000200, 32'h0badf00d, 4'b0011);
    expect_txn(0, 0, 1'b0, 1'b0, 32'h00000100, 32'h0, 4'hf, 1);
    expect_txn(0, 1, 1'b0, 1'b1, 32'h00000200, 32'h0badf00d, 4'b0011, 1);
    rem[0][0] = 1; rem[0][1] = 1;
    run(50, n);
    check("fixed_b2b_cycles", n, 5);

    // Timeout with busy held high: err after TMO+1 access cycles. The port's
    // address changes mid-access and must not reach the RAM.
    set_port(0, 0, 1'b0, 32'h00000300, 32'h0, 4'h0);
    busy_cfg[0] = 1000;
    expect_txn(0, 0, 1'b1, 1'b0, 32'h00000300, 32'h0, 4'hf, TMO + 1);
    rem[0][0] = 1;
    update_req();
    tick();
    tick();
    set_port(0, 0, 1'b0, 32'hdead0000, 32'h0, 4'h0);
    run(50, n);
    busy_cfg[0] = 0;
    set_port(0, 1, 1'b0, 32'h00000400, 32'h0, 4'h0);
    expect_txn(0, 1, 1'b0, 1'b0, 32'h00000400, 32'h0, 4'hf, 1);
    rem[0][1] = 1;
    run(50, n);
    check("after_timeout_latency", n, 2);

    // Reset during ACCESS: outputs clear at once, the held request is re-served.
    set_port(0, 1, 1'b0, 32'h00000500, 32'h0, 4'h0);
    busy_cfg[0] = 1000;
    rem[0][1] = 1;
    update_req();
    n = 0;
    while (!ren_f && n < 20) begin
      tick();
      n++;
    end
    check("ren_before_reset", ren_f, 1);
    tick();
    rst_f = 1'b1;
    #1;
    check("midrst_ren", ren_f, 0);
    check("midrst_wen", wen_f, 0);
    check("midrst_ack_err", {ack_f, err_f}, 0);
    check("midrst_rdata", rdata_f, 0);
    q_f.delete();
    acc_len[0] = 0; model_rd[0] = '0; busy_cfg[0] = 0; busy_f = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    rst_f = 1'b0;
    expect_txn(0, 1, 1'b0, 1'b0, 32'h00000500, 32'h0, 4'hf, 1);
    run(50, n);
    check("post_reset_latency", n, 2);

    // Round-robin, two ports requesting: grants 0, 1, 0, then 1.
    set_port(1, 0, 1'b0, 32'h00001000, 32'h0, 4'h0);
    set_port(1, 1, 1'b0, 32'h00002000, 32'h0, 4'h0);
    expect_txn(1, 0, 1'b0, 1'b0, 32'h00001000, 32'h0, 4'hf, 1);
    expect_txn(1, 1, 1'b0, 1'b0, 32'h00002000, 32'h0, 4'hf, 1);
    expect_txn(1, 0, 1'b0, 1'b0, 32'h00001000, 32'h0, 4'hf, 1);
    expect_txn(1, 1, 1'b0, 1'b0, 32'h00002000, 32'h0, 4'hf, 1);
    rem[1][0] = 2; rem[1][1] = 2;
    run(100, n);
    check("rr2_cycles", n, 11);

    // Round-robin, all four ports continuously: 0, 1, 2, 3, 0 after reset.
    reset_r();
    set_port(1, 0, 1'b0, 32'h00000010, 32'h0, 4'h0);
    set_port(1, 1, 1'b1, 32'h00000022, 32'hdead0001, cu_strb(CU_SH, 2'b10));
    set_port(1, 2, 1'b0, 32'h00000030, 32'h0, 4'h0);
    set_port(1, 3, 1'b1, 32'h00000043, 32'hbeef0003, cu_strb(CU_SB, 2'b11));
    busy_cfg[1] = 1;
    expect_txn(1, 0, 1'b0, 1'b0, 32'h00000010, 32'h0, 4'hf, 2);
    expect_txn(1, 1, 1'b0, 1'b1, 32'h00000022, 32'hdead0001, 4'b1100, 2);
    expect_txn(1, 2, 1'b0, 1'b0, 32'h00000030, 32'h0, 4'hf, 2);
    expect_txn(1, 3, 1'b0, 1'b1, 32'h00000043, 32'hbeef0003, 4'b1000, 2);
    expect_txn(1, 0, 1'b0, 1'b0, 32'h00000010, 32'h0, 4'hf, 2);
    rem[1][0] = 2; rem[1][1] = 1; rem[1][2] = 1; rem[1][3] = 1;
    run(200, n);
    check("rr4_cycles", n, 19);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_request_arbiter.md
# mem_request_arbiter

Parametrised N-port memory request arbiter that replaces the fixed instruction/data request block. Any number of requesters (port 0 is instruction fetch, port 1 is data by convention) share one RAM port. Arbitration is fixed-priority or round-robin. The block forwards byte strobes for sub-word stores, registers load data, and aborts accesses whose RAM busy signal never clears.

## Interface
- NPORTS, 2: number of requester ports (≥2)
- ADDR_W, 32: address width
- DATA_W, 32: data width, multiple of 8
- ARB_MODE, 0: 0 = fixed priority (lowest index wins), 1 = round-robin
- TIMEOUT, 255: maximum busy cycles before abort; 0 disables the abort
- CLK  in  1  clock, rising edge
- RST  in  1  reset, asynchronous, active-high
- req  in  NPORTS  per-port request, held until ack/err
- we  in  NPORTS  per-port write (1) / read (0)
- addr  in  NPORTS*ADDR_W  packed addresses, port i at [i*ADDR_W +: ADDR_W]
- wdata  in  NPORTS*DATA_W  packed store data
- strb  in  NPORTS*DATA_W/8  packed byte strobes, honoured on writes
- ack  out  NPORTS  one-cycle completion pulse to granted port
- err  out  NPORTS  one-cycle timeout pulse to granted port
- rdata  out  DATA_W  registered load data, valid while ack is high
- Ren  out  1  RAM read enable
- Wen  out  1  RAM write enable
- ramaddr  out  ADDR_W  RAM address
- ramstore  out  DATA_W  RAM store data
- ramstrb  out  DATA_W/8  RAM byte strobes (all ones on reads)
- ramload  in  DATA_W  RAM load data
- ram_busy  in  1  RAM still working on the current access

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE: if any req is high, pick grant g, latch we/addr/wdata/strb of port g into the command register, and go to ACCESS. Otherwise stay in IDLE.
- ACCESS: drive Ren = !we_l and Wen = we_l, with ramaddr/ramstore/ramstrb taken from the command register.
  - Access completes at the first rising edge with ram_busy = 0. At that edge, capture ramload into rdata on reads (rdata is unchanged on writes), set ack[g], and go to RESP.
  - A timeout counter increments each ACCESS cycle with ram_busy = 1. When it reaches TIMEOUT, set err[g] and go to RESP without updating rdata.
- RESP: Ren = Wen = 0. Exactly one of ack[g] or err[g] is high. Next state is IDLE.
- Fixed priority: g = lowest-index asserted req.
- Round-robin: the search starts at last_grant+1 modulo NPORTS. last_grant updates only on the IDLE→ACCESS transition. last_grant resets to NPORTS-1, so port 0 wins first.
- Requesters sample ack/err in RESP and may drop or change req at the following edge. req is only sampled in IDLE, so a held request is never granted twice.
- Changes to a port's addr/wdata after its grant do not affect the access in flight.
- Reset, including mid-ACCESS: state = IDLE; Ren, Wen, ack, err = 0; rdata, ramaddr, ramstore = 0; ramstrb = 0; counter = 0; last_grant = NPORTS-1. The outputs change asynchronously with RST.

## Timing
- Request seen in IDLE at edge k; Ren/Wen high from k to k+1.
- Minimum latency with ram_busy = 0 in the first ACCESS cycle: ack high in cycle k+2, i.e. 2 cycles from req to ack.
- Each ram_busy = 1 cycle adds one cycle of latency.
- Back-to-back throughput: one access per 3 + busy cycles (IDLE, ACCESS, RESP).
- Ren/Wen are registered, glitch-free, and never high together.
- ack/err are registered one-cycle pulses.
- Timeout: err asserts in cycle k+2+TIMEOUT when ram_busy is held high.

## Structure
- Package mem_arb_pkg holds:
  - the state typedef (IDLE, ACCESS, RESP);
  - ARB_FIXED = 0 and ARB_RR = 1;
  - the existing cuOPType, so callers can derive we/strb: SB gives one strobe bit at addr[1:0], SH gives two bits, SW gives all bits.
- One sub-module, rr_grant: combinational NPORTS-wide grant given a req vector, a last_grant pointer and the mode. It outputs a grant index and a valid flag.

## Test plan
- Single read, NPORTS = 2, fixed priority:
  - Stimulus: port 0 reads 0xabcdabcd, ram_busy high for 1 cycle, ramload = 0x12341234.
  - Required: Ren high for 2 cycles, ramaddr = 0xabcdabcd, ack[0] pulses once, rdata = 0x12341234, Wen never high.
- Store with strobes:
  - Stimulus: port 1 writes wdata = 0x33333333, addr = 0xabcdabcd, strb = 4'b0001 (SB).
  - Required: Wen high, ramstore = 0x33333333, ramstrb = 4'b0001, ack[1] pulses, rdata unchanged.
- Simultaneous requests:
  - Stimulus: ports 0 and 1 both request at once. Fixed mode: port 0 acks first, then port 1. Round-robin with three consecutive dual-request rounds.
  - Required: grants alternate 0, 1, 0.
- Timeout:
  - Stimulus: TIMEOUT = 4, ram_busy held high.
  - Required: err[g] pulses in the 7th cycle after grant edge k (cycle k+6), ack never asserts, FSM returns to IDLE and serves the next request normally.
- Reset mid-ACCESS:
  - Stimulus: assert RST while Ren is high.
  - Required: Ren, Wen, ack, err = 0 immediately (before the next edge). After release, the pending req is re-arbitrated and completes with the correct ack.
- Round-robin with NPORTS = 4:
  - Stimulus: all four ports request continuously.
  - Required: grant order 0, 1, 2, 3, 0, with each port's ramaddr matching its own addr.
